// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared arbiter state encoding and default MMIO map
// Also imported by the top-level display mux for the OUT word addresses.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FORCE = 2'd1,
      ST_GRANT = 2'd2
   } arb_state_t;

   localparam logic [31:0] DEF_IN1_ADDR  = 32'h0;
   localparam logic [31:0] DEF_IN2_ADDR  = 32'h4;
   localparam logic [31:0] DEF_OUT1_ADDR = 32'h8;
   localparam logic [31:0] DEF_OUT2_ADDR = 32'hC;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - touch-screen host write channel (valid/ready)
interface dmem_arbiter_if #(
   parameter int DATA_W = 32
) ();

   logic              host_valid;
   logic              host_ready;
   logic [DATA_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;

   modport master (output host_valid, host_addr, host_wdata, input host_ready);
   modport slave  (input host_valid, host_addr, host_wdata, output host_ready);

endinterface

// File: rtl/dmem_arb_fifo.sv
// rtl/dmem_arb_fifo.sv - synchronous FIFO buffering host writes, exposes occupancy
module dmem_arb_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             inclk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign head = mem[rd_ptr];

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge inclk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge inclk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - DataMem port arbiter between CPU and buffered host writer
// Optional hit counters enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int                DATA_W       = 32,
   parameter logic [DATA_W-1:0] IN1_ADDR     = DATA_W'(DEF_IN1_ADDR),
   parameter logic [DATA_W-1:0] IN2_ADDR     = DATA_W'(DEF_IN2_ADDR),
   parameter logic [DATA_W-1:0] OUT1_ADDR    = DATA_W'(DEF_OUT1_ADDR),
   parameter logic [DATA_W-1:0] OUT2_ADDR    = DATA_W'(DEF_OUT2_ADDR),
   parameter int                FIFO_DEPTH   = 4,
   parameter int                STARVE_LIMIT = 8
) (
   input  logic              inclk,
   input  logic              rstn,
   input  logic              cpu_cs,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hold,
   dmem_arbiter_if.slave     host,
   output logic              host_err,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [15:0]       stat_grants,
   output logic [15:0]       stat_forced
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT) + 1;

   arb_state_t          state;
   logic [SW-1:0]       starve_cnt;
   logic [CW-1:0]       fifo_count;
   logic [2*DATA_W-1:0] fifo_head;
   logic                host_hs;
   logic                addr_ok;
   logic                push_ok;
   logic                pending;
   logic                grant;

   assign host.host_ready = (fifo_count < CW'(FIFO_DEPTH));
   assign host_hs = host.host_valid & host.host_ready;
   assign addr_ok = (host.host_addr == IN1_ADDR) || (host.host_addr == IN2_ADDR);
   assign push_ok = host_hs & addr_ok;
   // An entry being pushed this cycle already counts, so an idle CPU sees the grant next cycle.
   assign pending = (fifo_count != '0) | push_ok;
   assign grant   = (state == ST_GRANT);

   dmem_arb_fifo #(
      .WIDTH (2 * DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .inclk     (inclk),
      .rstn      (rstn),
      .push      (push_ok),
      .push_data ({host.host_addr, host.host_wdata}),
      .pop       (grant),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   always_ff @(posedge inclk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         cpu_hold   <= 1'b0;
         starve_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!pending) begin
                  starve_cnt <= '0;
               end else if (!cpu_cs) begin
                  state    <= ST_GRANT;
                  cpu_hold <= 1'b1;
               end else if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                  state    <= ST_FORCE;
                  cpu_hold <= 1'b1;
               end else begin
                  starve_cnt <= starve_cnt + 1'b1;
               end
            end
            ST_FORCE: begin
               state    <= ST_GRANT;
               cpu_hold <= 1'b1;
            end
            ST_GRANT: begin
               state      <= ST_IDLE;
               cpu_hold   <= 1'b0;
               starve_cnt <= '0;
            end
            default: begin
               state    <= ST_IDLE;
               cpu_hold <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      mem_cs    = cpu_cs;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (grant) begin
         mem_cs    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = fifo_head[2*DATA_W-1:DATA_W];
         mem_wdata = fifo_head[DATA_W-1:0];
      end
   end

   assign cpu_rdata = (state == ST_IDLE) ? mem_rdata : '0;

   always_ff @(posedge inclk or negedge rstn) begin
      if (!rstn) begin
         out1     <= '0;
         out2     <= '0;
         host_err <= 1'b0;
      end else begin
         if (mem_cs && mem_we && mem_addr == OUT1_ADDR) out1 <= mem_wdata;
         if (mem_cs && mem_we && mem_addr == OUT2_ADDR) out2 <= mem_wdata;
         if (host_hs && !addr_ok) host_err <= 1'b1;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge inclk or negedge rstn) begin
      if (!rstn) begin
         stat_grants <= '0;
         stat_forced <= '0;
      end else begin
         if (state == ST_GRANT && stat_grants != 16'hFFFF) stat_grants <= stat_grants + 1'b1;
         if (state == ST_FORCE && stat_forced != 16'hFFFF) stat_forced <= stat_forced + 1'b1;
      end
   end
`else
   assign stat_grants = '0;
   assign stat_forced = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized bench against a queue-based arbiter model
module tb_dmem_arbiter;

   logic        inclk = 1'b0;
   logic        rstn;
   logic        cpu_cs, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_hold, host_err;
   logic        mem_cs, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] out1, out2;
   logic [15:0] stat_grants, stat_forced;

   always #5 inclk = ~inclk;

   dmem_arbiter_if #(.DATA_W(32)) hif ();

   dmem_arbiter dut (
      .inclk       (inclk),
      .rstn        (rstn),
      .cpu_cs      (cpu_cs),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_hold    (cpu_hold),
      .host        (hif),
      .host_err    (host_err),
      .mem_cs      (mem_cs),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .out1        (out1),
      .out2        (out2),
      .stat_grants (stat_grants),
      .stat_forced (stat_forced)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   // Model: pending host words, who owns the port this cycle, busy-cycle streak.
   ent_t        q[$];
   int          owner;      // 0 cpu, 1 cpu frozen before host slot, 2 host slot
   int          streak;
   int          m_grants, m_forced;
   logic [31:0] m_out1, m_out2;
   logic        m_err;
   int          n_tests, n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      owner = 0; streak = 0; m_grants = 0; m_forced = 0;
      m_out1 = '0; m_out2 = '0; m_err = 1'b0;
   endtask

   task automatic check_cycle();
      logic        host_slot;
      logic [31:0] e_addr, e_wdata;
      host_slot = (owner == 2) && (q.size() > 0);
      e_addr  = host_slot ? q[0].a : cpu_addr;
      e_wdata = host_slot ? q[0].d : cpu_wdata;
      check("cpu_hold",   32'(cpu_hold),        32'(owner != 0));
      check("host_ready", 32'(hif.host_ready),  32'(q.size() < 4));
      check("mem_cs",     32'(mem_cs),          32'(host_slot | cpu_cs));
      check("mem_we",     32'(mem_we),          32'(host_slot | cpu_we));
      check("mem_addr",   mem_addr,             e_addr);
      check("mem_wdata",  mem_wdata,            e_wdata);
      check("cpu_rdata",  cpu_rdata,            (owner == 0) ? mem_rdata : 32'h0);
      check("out1",       out1,                 m_out1);
      check("out2",       out2,                 m_out2);
      check("host_err",   32'(host_err),        32'(m_err));
`ifdef DMEM_ARB_STATS_EN
      check("stat_grants", 32'(stat_grants), 32'(m_grants));
      check("stat_forced", 32'(stat_forced), 32'(m_forced));
`else
      check("stat_grants", 32'(stat_grants), 32'h0);
      check("stat_forced", 32'(stat_forced), 32'h0);
`endif
   endtask

   task automatic model_step();
      logic        ready, hs, ok, pend, bcs, bwe, host_slot;
      logic [31:0] ba, bd;
      int          prev;
      ready = q.size() < 4;
      hs    = hif.host_valid && ready;
      ok    = hs && (hif.host_addr == 32'h0 || hif.host_addr == 32'h4);
      if (hs && !ok) m_err = 1'b1;
      host_slot = (owner == 2) && (q.size() > 0);
      bcs = host_slot | cpu_cs;
      bwe = host_slot | cpu_we;
      ba  = host_slot ? q[0].a : cpu_addr;
      bd  = host_slot ? q[0].d : cpu_wdata;
      if (bcs && bwe && ba == 32'h8) m_out1 = bd;
      if (bcs && bwe && ba == 32'hC) m_out2 = bd;
      pend = (q.size() > 0) || ok;
      prev = owner;
      if (owner == 2) begin
         owner = 0; streak = 0;
         void'(q.pop_front());
         if (m_grants < 65535) m_grants++;
      end else if (owner == 1) begin
         owner = 2;
         if (m_forced < 65535) m_forced++;
      end else if (!pend) begin
         streak = 0;
      end else if (!cpu_cs) begin
         owner = 2;
      end else if (streak == 7) begin
         owner = 1;
      end else begin
         streak++;
      end
      if (ok) q.push_back('{a: hif.host_addr, d: hif.host_wdata});
      if (prev == 2 && q.size() > 4) check("model_overflow", 32'(q.size()), 32'd4);
   endtask

   task automatic cyc(input logic cs, input logic we, input logic [31:0] ca, input logic [31:0] cd,
                      input logic hv, input logic [31:0] ha, input logic [31:0] hd);
      @(posedge inclk);
      #1;
      cpu_cs = cs; cpu_we = we; cpu_addr = ca; cpu_wdata = cd;
      hif.host_valid = hv; hif.host_addr = ha; hif.host_wdata = hd;
      mem_rdata = $urandom;
      #1;
      check_cycle();
      model_step();
   endtask

   function automatic logic [31:0] pick_addr(input int sel);
      case (sel)
         0: return 32'h0;
         1: return 32'h4;
         2: return 32'h8;
         3: return 32'hC;
         default: return $urandom & 32'h0000_0FFC;
      endcase
   endfunction

   task automatic rand_cyc(input int busy_pct, input int host_pct);
      logic [31:0] ha;
      ha = ($urandom_range(0, 9) < 8) ? pick_addr($urandom_range(0, 1)) : pick_addr($urandom_range(2, 4));
      cyc($urandom_range(0, 99) < busy_pct, 1'($urandom), pick_addr($urandom_range(0, 4)), $urandom,
          $urandom_range(0, 99) < host_pct, ha, $urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) cyc(0, 0, 0, 0, 0, 0, 0);
      check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   initial begin
      int h_at, g_at, acc_at;
      n_tests = 0; n_fail = 0;
      rstn = 1'b0;
      cpu_cs = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; mem_rdata = 0;
      hif.host_valid = 0; hif.host_addr = 0; hif.host_wdata = 0;
      model_reset();
      #12;
      check("rst_hold",  32'(cpu_hold),       32'h0);
      check("rst_mem_cs", 32'(mem_cs),        32'h0);
      check("rst_out1",  out1,                32'h0);
      check("rst_err",   32'(host_err),       32'h0);
      @(negedge inclk);
      rstn = 1'b1;
      check("rst_ready", 32'(hif.host_ready), 32'h1);

      // Idle CPU: push lands in memory the very next cycle.
      cyc(0, 0, 0, 0, 1, 32'h0, 32'h1234);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("push_cs",    32'(mem_cs && mem_we), 32'h1);
      check("push_addr",  mem_addr,              32'h0);
      check("push_wdata", mem_wdata,             32'h1234);
      check("push_hold",  32'(cpu_hold),         32'h1);
      cyc(0, 0, 0, 0, 0, 0, 0);

      // Busy CPU starvation: freeze after 8 busy cycles, write on the 9th.
      cyc(1, 0, 32'h40, 0, 1, 32'h4, 32'h55);
      h_at = -1; g_at = -1;
      for (int i = 1; i <= 20 && g_at < 0; i++) begin
         cyc(1, 0, 32'h40, 0, 0, 0, 0);
         if (h_at < 0 && cpu_hold) h_at = i;
         if (g_at < 0 && mem_we) g_at = i;
      end
      check("starve_force_cycle", 32'(h_at), 32'd8);
      check("starve_grant_cycle", 32'(g_at), 32'd9);
      cyc(1, 0, 32'h40, 0, 0, 0, 0);

      // Fill the buffer while the CPU is busy; 5th push waits for the first pop.
      for (int i = 0; i < 4; i++) cyc(1, 0, 32'h40, 0, 1, 32'h4, 32'(i));
      acc_at = -1;
      for (int k = 4; k < 30 && acc_at < 0; k++) begin
         cyc(1, 0, 32'h40, 0, 1, 32'h0, 32'hF5);
         if (k == 4) check("full_ready", 32'(hif.host_ready), 32'h0);
         if (hif.host_ready) acc_at = k;
      end
      check("fifth_accept_cycle", 32'(acc_at), 32'd10);
      drain();

      // MMIO capture and host address filtering.
      cyc(1, 1, 32'h8, 32'hDEAD_BEEF, 0, 0, 0);
      cyc(1, 1, 32'hC, 32'h5, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h8, 32'h9999);
      check("mmio_out1", out1, 32'hDEAD_BEEF);
      check("mmio_out2", out2, 32'h5);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("filter_err",  32'(host_err), 32'h1);
      check("filter_out1", out1,          32'hDEAD_BEEF);

      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 300; i++) rand_cyc((p == 0) ? 100 : (p == 1) ? 70 : 20, 45);
      end
      drain();

      // Reset during a host slot abandons the write at once.
      cyc(0, 0, 0, 0, 1, 32'h4, 32'hAB);
      @(posedge inclk);
      #1;
      cpu_cs = 0; cpu_we = 0; hif.host_valid = 0;
      #1;
      check("pre_rst_grant", 32'(mem_cs), 32'h1);
      rstn = 1'b0;
      #1;
      check("mid_rst_mem_cs", 32'(mem_cs),          32'h0);
      check("mid_rst_hold",   32'(cpu_hold),        32'h0);
      check("mid_rst_ready",  32'(hif.host_ready),  32'h1);
      check("mid_rst_out1",   out1,                 32'h0);
      model_reset();
      @(negedge inclk);
      @(negedge inclk);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) rand_cyc(50, 50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
